// File: rtl/prime_pkg.sv
// Shared types and default widths for the prime_engine request/response block.
package prime_pkg;

  localparam int PRIME_N_W = 4;
  localparam int PRIME_P_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CAND,
    MOD,
    EVAL,
    FOUND,
    NEXT,
    DONE
  } prime_state_t;

endpackage

// File: rtl/prime_rem_seq.sv
// Sequential remainder unit: repeated subtraction, one divisor per clock.
module prime_rem_seq
  import prime_pkg::*;
#(
  parameter int P_W = PRIME_P_W
) (
  input  logic           clk,
  input  logic           load,
  input  logic [P_W-1:0] dividend,
  input  logic [P_W-1:0] divisor,
  output logic           done,
  output logic [P_W-1:0] remainder
);

  logic [P_W-1:0] rem_q;

  // Once rem drops below the divisor it holds, so the value is stable for inspection.
  assign done      = (rem_q < divisor);
  assign remainder = rem_q;

  always_ff @(posedge clk) begin
    if (load) begin
      rem_q <= dividend;
    end else if (!done) begin
      rem_q <= rem_q - divisor;
    end
  end

endmodule

// File: rtl/prime_engine.sv
// Returns the n-th prime (1-indexed) found by sequential trial division,
// with a valid/ready request and response handshake.
module prime_engine
  import prime_pkg::*;
#(
  parameter int N_W = PRIME_N_W,
  parameter int P_W = PRIME_P_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid_i,
  input  logic [N_W-1:0] req_n_i,
  output logic           req_ready_o,
  output logic           rsp_valid_o,
  output logic [P_W-1:0] rsp_prime_o,
  output logic           rsp_err_o,
  input  logic           rsp_ready_i,
  output logic           busy_o
);

  localparam int DSQ_W = P_W + 2;
  localparam logic [P_W-1:0]   CAND_MAX = {P_W{1'b1}};
  localparam logic [DSQ_W-1:0] DSQ_INIT = DSQ_W'(4);

  prime_state_t     state_q, state_d;
  logic [N_W-1:0]   n_q, count_q, count_inc;
  logic [P_W-1:0]   cand_q, d_q;
  logic [DSQ_W-1:0] dsq_q, dsq_nxt, cand_ext;
  logic [P_W-1:0]   prime_q;
  logic             err_q;
  logic             rem_load, rem_done;
  logic [P_W-1:0]   rem;

  // (d+1)^2 = d^2 + 2d + 1; the extra two bits keep this from wrapping.
  function automatic logic [DSQ_W-1:0] dsq_step(input logic [DSQ_W-1:0] dsq,
                                                input logic [P_W-1:0]   d);
    return dsq + {1'b0, d, 1'b1};
  endfunction

  assign dsq_nxt   = dsq_step(dsq_q, d_q);
  assign cand_ext  = {2'b00, cand_q};
  assign count_inc = count_q + N_W'(1);

  prime_rem_seq #(.P_W(P_W)) u_rem (
    .clk       (clk),
    .load      (rem_load),
    .dividend  (cand_q),
    .divisor   (d_q),
    .done      (rem_done),
    .remainder (rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_load    = 1'b0;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) state_d = (req_n_i == '0) ? DONE : CAND;
      end
      CAND: begin
        rem_load = 1'b1;
        state_d  = (DSQ_INIT > cand_ext) ? FOUND : MOD;
      end
      MOD: begin
        if (rem_done) state_d = EVAL;
      end
      EVAL: begin
        if (rem == '0) begin
          state_d = NEXT;
        end else begin
          rem_load = 1'b1;
          state_d  = (dsq_nxt > cand_ext) ? FOUND : MOD;
        end
      end
      FOUND:   state_d = (count_inc == n_q) ? DONE : NEXT;
      NEXT:    state_d = (cand_q == CAND_MAX) ? DONE : CAND;
      DONE: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Search datapath: only the FSM state qualifies these, so no reset is needed.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          n_q     <= req_n_i;
          cand_q  <= P_W'(2);
          count_q <= '0;
        end
      end
      CAND: begin
        d_q   <= P_W'(2);
        dsq_q <= DSQ_INIT;
      end
      EVAL: begin
        if (rem != '0) begin
          d_q   <= d_q + P_W'(1);
          dsq_q <= dsq_nxt;
        end
      end
      FOUND: count_q <= count_inc;
      NEXT: begin
        if (cand_q != CAND_MAX) cand_q <= cand_q + P_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_n_i == '0) begin
            prime_q <= '0;
            err_q   <= 1'b1;
          end
        end
        FOUND: begin
          if (count_inc == n_q) begin
            prime_q <= cand_q;
            err_q   <= 1'b0;
          end
        end
        NEXT: begin
          if (cand_q == CAND_MAX) begin
            prime_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_prime_o = prime_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_prime_engine.sv
// Scoreboard bench for prime_engine: an 8-bit and a 4-bit instance share stimulus.
module tb_prime_engine;

  typedef struct {
    int prime;
    bit err;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_n;
  logic       rsp_ready;
  logic       sel;

  logic       v8, r8, e8, b8;
  logic [7:0] p8;
  logic       v4, r4, e4, b4;
  logic [3:0] p4;

  logic       o_valid, o_ready, o_err, o_busy;
  logic [7:0] o_prime;

  int   cyc = 0;
  int   acc_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prime_engine #(.N_W(4), .P_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid & ~sel), .req_n_i(req_n),
    .req_ready_o(r8), .rsp_valid_o(v8), .rsp_prime_o(p8), .rsp_err_o(e8),
    .rsp_ready_i(rsp_ready), .busy_o(b8)
  );

  prime_engine #(.N_W(4), .P_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid & sel), .req_n_i(req_n),
    .req_ready_o(r4), .rsp_valid_o(v4), .rsp_prime_o(p4), .rsp_err_o(e4),
    .rsp_ready_i(rsp_ready), .busy_o(b4)
  );

  assign o_valid = sel ? v4 : v8;
  assign o_ready = sel ? r4 : r8;
  assign o_err   = sel ? e4 : e8;
  assign o_busy  = sel ? b4 : b8;
  assign o_prime = sel ? {4'b0000, p4} : p8;

  // Reference: trial-division search, counting one cycle per state visit.
  function automatic void model(input int n, input int pw,
                                output int prime, output bit err, output int lat);
    int cand, d, dsq, rem, count, maxc;
    bit done, isp, fin;
    lat = 1; prime = 0; err = 0;
    if (n == 0) begin
      err = 1;
      return;
    end
    cand = 2; count = 0; maxc = (1 << pw) - 1; fin = 0;
    while (!fin) begin
      lat++;
      d = 2; dsq = 4; rem = cand; isp = (dsq > cand); done = isp;
      while (!done) begin
        lat++;
        while (rem >= d) begin
          rem -= d;
          lat++;
        end
        lat++;
        if (rem == 0) done = 1;
        else begin
          d++; dsq = d * d; rem = cand;
          if (dsq > cand) begin isp = 1; done = 1; end
        end
      end
      if (isp) begin
        lat++; count++;
        if (count == n) begin prime = cand; fin = 1; end
      end
      if (!fin) begin
        lat++;
        if (cand == maxc) begin err = 1; fin = 1; end
        else cand++;
      end
    end
  endfunction

  task automatic issue(input int n, input int pw, output bit ok);
    exp_t e;
    int p, l;
    bit er;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (o_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    req_valid = 1'b1;
    req_n = 4'(n);
    model(n, pw, p, er, l);
    e.prime = p; e.err = er; e.lat = l;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int gp, output bit ge, output int gl, output bit ok);
    ok = 0; gp = -1; ge = 0; gl = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        gp = int'(o_prime); ge = o_err; gl = cyc - acc_cyc + 1; ok = 1;
        break;
      end
    end
  endtask

  task automatic round_trip(input int n, input int pw, output exp_t e,
                            output int gp, output bit ge, output int gl, output bit ok);
    e.prime = -2; e.err = 0; e.lat = -2;
    gp = -1; ge = 0; gl = -1;
    issue(n, pw, ok);
    if (!ok) return;
    wait_rsp(gp, ge, gl, ok);
    if (sbq.size() > 0) e = sbq.pop_front();
  endtask

  task automatic test_reset();
    sel = 0; rst_n = 0; req_valid = 0; req_n = 0; rsp_ready = 1;
    repeat (10) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", r8); end
    checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", v8); end
    checks++; if (p8 !== 8'd0) begin errors++; $display("FAIL reset_prime got %0d want 0", p8); end
    checks++; if (e8 !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", e8); end
    checks++; if (b8 !== 1'b0 || b4 !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b%b want 00", b8, b4);
    end
  endtask

  task automatic test_basic();
    int ns[5] = '{1, 2, 3, 6, 0};
    int ps[5] = '{2, 3, 5, 13, 0};
    exp_t e;
    int gp, gl;
    bit ge, ok;
    sel = 0; rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      round_trip(ns[i], 8, e, gp, ge, gl, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout n=%0d got none want response", ns[i]); continue; end
      checks++; if (gp !== e.prime || gp !== ps[i]) begin
        errors++; $display("FAIL basic_prime n=%0d got %0d want %0d", ns[i], gp, ps[i]);
      end
      checks++; if (ge !== e.err || ge !== (ns[i] == 0)) begin
        errors++; $display("FAIL basic_err n=%0d got %b want %b", ns[i], ge, e.err);
      end
      checks++; if (gl !== e.lat) begin
        errors++; $display("FAIL basic_latency n=%0d got %0d want %0d", ns[i], gl, e.lat);
      end
      if (ns[i] == 1) begin
        checks++; if (gl !== 3) begin errors++; $display("FAIL lat_n1 got %0d want 3", gl); end
      end
      if (ns[i] == 0) begin
        checks++; if (gl !== 1) begin errors++; $display("FAIL lat_n0 got %0d want 1", gl); end
      end
      @(negedge clk);
      checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
        errors++; $display("FAIL rsp_handshake got v=%b r=%b b=%b want 0 1 0", o_valid, o_ready, o_busy);
      end
    end
  endtask

  task automatic test_overflow();
    int ns[2] = '{7, 6};
    int ps[2] = '{0, 13};
    int es[2] = '{1, 0};
    exp_t e;
    int gp, gl;
    bit ge, ok;
    sel = 1; rsp_ready = 1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      round_trip(ns[i], 4, e, gp, ge, gl, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ovf_timeout n=%0d got none want response", ns[i]); continue; end
      checks++; if (gp !== e.prime || gp !== ps[i]) begin
        errors++; $display("FAIL ovf_prime n=%0d got %0d want %0d", ns[i], gp, ps[i]);
      end
      checks++; if (int'(ge) !== es[i] || ge !== e.err) begin
        errors++; $display("FAIL ovf_err n=%0d got %b want %0d", ns[i], ge, es[i]);
      end
      checks++; if (gl !== e.lat) begin
        errors++; $display("FAIL ovf_latency n=%0d got %0d want %0d", ns[i], gl, e.lat);
      end
      @(negedge clk);
    end
    sel = 0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int gp, gl;
    bit ge, ok;
    sel = 0; rsp_ready = 0;
    issue(4, 8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_issue got not_ready want ready"); return; end
    wait_rsp(gp, ge, gl, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got none want response"); return; end
    e = sbq.pop_front();
    checks++; if (gp !== e.prime || gp !== 7) begin
      errors++; $display("FAIL bp_prime got %0d want 7", gp);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin req_valid = 1'b1; req_n = 4'd1; end
      if (i == 3) req_valid = 1'b0;
      @(negedge clk);
      checks++; if (o_valid !== 1'b1 || o_prime !== 8'd7 || o_err !== 1'b0 || o_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d got v=%b p=%0d r=%b want 1 7 0", i, o_valid, o_prime, o_ready);
      end
    end
    rsp_ready = 1;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got v=%b r=%b b=%b want 0 1 0", o_valid, o_ready, o_busy);
    end
    round_trip(5, 8, e, gp, ge, gl, ok);
    checks++; if (!ok || gp !== 11 || gp !== e.prime || ge !== 1'b0) begin
      errors++; $display("FAIL bp_next got %0d err=%b want 11 err=0", gp, ge);
    end
    checks++; if (gl !== e.lat) begin
      errors++; $display("FAIL bp_next_latency got %0d want %0d", gl, e.lat);
    end
    checks++; if (sbq.size() !== 0) begin
      errors++; $display("FAIL bp_queue got %0d want 0", sbq.size());
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    exp_t e;
    int gp, gl;
    bit ge, ok;
    sel = 0; rsp_ready = 1;
    issue(6, 8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ar_issue got not_ready want ready"); return; end
    sbq.delete();
    // Seven edges after acceptance the engine is dividing candidate 4 (MOD state).
    repeat (7) @(posedge clk);
    #2;
    checks++; if (b8 !== 1'b1) begin errors++; $display("FAIL ar_busy_before got %b want 1", b8); end
    rst_n = 0;
    #1;
    checks++; if (r8 !== 1'b1 || v8 !== 1'b0 || b8 !== 1'b0) begin
      errors++; $display("FAIL ar_ctrl got r=%b v=%b b=%b want 1 0 0", r8, v8, b8);
    end
    checks++; if (p8 !== 8'd0 || e8 !== 1'b0) begin
      errors++; $display("FAIL ar_data got p=%0d e=%b want 0 0", p8, e8);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    round_trip(2, 8, e, gp, ge, gl, ok);
    checks++; if (!ok || gp !== 3 || gp !== e.prime || ge !== 1'b0) begin
      errors++; $display("FAIL ar_after got %0d err=%b want 3 err=0", gp, ge);
    end
    checks++; if (gl !== e.lat) begin
      errors++; $display("FAIL ar_after_latency got %0d want %0d", gl, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no_finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prime_engine.md
# prime_engine

- Responder side of the user-to-engine request/response link.
- Accepts an index `n` from the user controller, computes the n-th prime (1-indexed: 1→2, 2→3, 3→5) by sequential trial division, and returns it with a two-phase valid/ready handshake.
- Sits between the button/LED user controller and the display path. One request is in flight at a time.

## Interface

Parameters:
- `N_W`, default 4: width of the requested index.
- `P_W`, default 8: width of the candidate and result; primes above `2**P_W-1` are unrepresentable.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req_valid_i`, input, 1: request present.
- `req_n_i`, input, `N_W`: requested prime index.
- `req_ready_o`, output, 1: engine idle and able to accept a request.
- `rsp_valid_o`, output, 1: response present.
- `rsp_prime_o`, output, `P_W`: result prime.
- `rsp_err_o`, output, 1: request invalid (`n=0`) or result overflowed `P_W`.
- `rsp_ready_i`, input, 1: consumer accepts the response.
- `busy_o`, output, 1: engine is between request acceptance and response completion.

## Operation

**Reset**
- State returns to IDLE immediately on `rst_n` low, including mid-computation; any in-progress result is discarded.
- Reset output values: `req_ready_o=1`, `rsp_valid_o=0`, `rsp_prime_o=0`, `rsp_err_o=0`, `busy_o=0`.

**Request acceptance**
- A request is accepted at a rising edge where `req_valid_i && req_ready_o`.
- `req_n_i` is captured into `n_q`.
- `req_ready_o` is 1 only in IDLE.
- `busy_o` is 1 in every state except IDLE.

**States**
- IDLE: on accept:
  - if `n=0`, go to DONE with `err=1`, `prime=0`;
  - otherwise set `cand=2`, `count=0`, and go to CAND.
- CAND: set `d=2`, `d_sq=4`, `rem=cand`. If `d_sq>cand`, the candidate is prime, go to FOUND; else go to MOD.
- MOD: one subtraction per cycle. If `rem>=d`, set `rem<=rem-d` and stay; else go to EVAL.
- EVAL:
  - if `rem==0`, the candidate is composite, go to NEXT;
  - else `d<=d+1`, `d_sq<=d_sq+2d+1`, `rem<=cand`;
  - if the new `d_sq>cand`, go to FOUND, else go to MOD.
- FOUND: `count<=count+1`. If `count+1==n_q`, go to DONE with `prime=cand`, `err=0`; else go to NEXT.
- NEXT: if `cand==2**P_W-1`, go to DONE with `err=1`, `prime=0`; else `cand<=cand+1` and go to CAND.
- DONE: `rsp_valid_o=1`; `rsp_prime_o` and `rsp_err_o` are stable. On `rsp_ready_i`, go to IDLE.

**Arithmetic and width rules**
- `d` is `P_W` bits wide.
- `d_sq` is `P_W+2` bits wide and never wraps.
- `count` is `N_W` bits wide.
- All comparisons are unsigned.

**Boundary conditions**
- `req_valid_i` asserted while busy is ignored: it is not queued and produces no effect.
- In DONE, `req_ready_o=0`. The request line and the response line never complete a handshake in the same cycle.
- `rsp_ready_i` asserted outside DONE is ignored.

## Timing

- Each state above lasts exactly one cycle per visit; only MOD repeats.
- Latency from acceptance edge to `rsp_valid_o` rising:
  - `n=0`: 1 cycle.
  - `n=1`: 3 cycles (IDLE→CAND→FOUND→DONE).
  - In general, the latency is the sum of state visits under the model above. The bench computes it from a reference model and checks it exactly.
- Response handshake: `rsp_valid_o` falls in the cycle after the edge where it is sampled together with `rsp_ready_i`. `req_ready_o` rises in that same cycle.
- Back-to-back operation: a new request can be accepted at the second edge after response completion at the earliest.
- Outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Structure

- Package `prime_pkg`:
  - state enum `prime_state_t` with members IDLE, CAND, MOD, EVAL, FOUND, NEXT, DONE;
  - default constants `PRIME_N_W=4`, `PRIME_P_W=8`.
- Single sub-module `prime_rem_seq`: a sequential remainder unit.
  - Inputs: load, dividend, divisor.
  - Outputs: done, remainder.
  - It implements the MOD loop and is instantiated once.
- The top-level `prime_engine` holds the FSM, `cand`, `count`, `d`, and `d_sq`.

## Test plan

- Reset held for 10 cycles and then released → `req_ready_o=1`, `rsp_valid_o=0`, `rsp_prime_o=0`, `busy_o=0`.
- Requests `n=1`, `2`, `3`, `6`, with `rsp_ready_i` held at 1 → `rsp_prime_o` = 2, 3, 5, 13 respectively, `rsp_err_o=0`. The `n=1` response arrives exactly 3 cycles after acceptance.
- Request `n=0` → response on the next cycle with `err=1`, `prime=0`.
- Instance with `P_W=4`, request `n=7` → `err=1`, `prime=0`. Request `n=6` → 13, `err=0`.
- Request `n=4` with `rsp_ready_i=0` for 8 cycles:
  - `rsp_valid_o` holds with `prime=7` throughout;
  - a second `req_valid_i` pulse during this interval is ignored.
  - After `rsp_ready_i` is raised, the engine returns to IDLE and the next request (`n=5`) returns 11.
- `rst_n` pulsed low during the MOD state of `n=6` → outputs go to reset values asynchronously. A following `n=2` request returns 3.
